// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master round-robin arbiter and access sequencer for the data memory
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   mN_req/addr/wdata/    request from master N (0 = core load/store, 1 = loader/debug),
//   mN_we/mN_funct3       held high until mN_ack; funct3 is the RV32 load/store encoding
//   mN_ack/rdata/err      one-cycle completion pulse with registered load data and error flag
//   mem_addr/wdata/we/    single data-memory port, driven from the latched request
//   mem_funct3
//   mem_rdata             combinational read data returned by the memory
//
// Optional feature: define DMEM_ARB_MISALIGN_EN to also flag misaligned half/word
// accesses as errors; by default they pass to the memory unchanged.
module dmem_arbiter #(
  parameter int MEM_BYTES = 2048
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_we,
  input  logic [2:0]  m0_funct3,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_we,
  input  logic [2:0]  m1_funct3,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nx;
  logic        last_grant;   // master granted most recently
  logic        grant;        // master owning the access in flight
  logic [31:0] lat_addr, lat_wdata, resp_rdata;
  logic [2:0]  lat_funct3;
  logic        lat_we, lat_err;

  logic        sel;
  logic [31:0] sel_addr, sel_wdata;
  logic [2:0]  sel_funct3;
  logic        sel_we, sel_err;
  logic [32:0] size_m1, last_byte;
  logic        take;

  // Round-robin: m1 wins when alone, or when both ask and m0 was served last.
  always_comb begin
    sel        = m1_req & (~m0_req | ~last_grant);
    sel_addr   = sel ? m1_addr   : m0_addr;
    sel_wdata  = sel ? m1_wdata  : m0_wdata;
    sel_we     = sel ? m1_we     : m0_we;
    sel_funct3 = sel ? m1_funct3 : m0_funct3;
    take       = (state == IDLE) & (m0_req | m1_req);
  end

  // Range check in 33 bits so an access near 0xFFFFFFFF cannot wrap into range.
  always_comb begin
    case (sel_funct3[1:0])
      2'b00:   size_m1 = 33'd0;
      2'b01:   size_m1 = 33'd1;
      2'b10:   size_m1 = 33'd3;
      default: size_m1 = 33'd0;
    endcase
    last_byte = {1'b0, sel_addr} + size_m1;
    sel_err   = (sel_funct3[1:0] == 2'b11) | (last_byte >= 33'(MEM_BYTES));
`ifdef DMEM_ARB_MISALIGN_EN
    if ((sel_funct3[1:0] == 2'b01) && sel_addr[0])
      sel_err = 1'b1;
    if ((sel_funct3[1:0] == 2'b10) && (sel_addr[1:0] != 2'b00))
      sel_err = 1'b1;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (m0_req | m1_req) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      grant      <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      lat_we     <= 1'b0;
      lat_funct3 <= 3'd0;
      lat_err    <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      if (take) begin
        last_grant <= sel;
        grant      <= sel;
        lat_addr   <= sel_addr;
        lat_wdata  <= sel_wdata;
        lat_we     <= sel_we;
        lat_funct3 <= sel_funct3;
        lat_err    <= sel_err;
      end
      if (state == ACCESS)
        resp_rdata <= (~lat_we & ~lat_err) ? mem_rdata : 32'd0;
    end
  end

  // mem_we and the acks decode the state register, so an asynchronous reset
  // removes them immediately and an interrupted store never commits.
  always_comb begin
    mem_addr   = lat_addr;
    mem_wdata  = lat_wdata;
    mem_funct3 = lat_funct3;
    mem_we     = (state == ACCESS) & lat_we & ~lat_err;
    m0_ack     = (state == RESP) & ~grant;
    m1_ack     = (state == RESP) & grant;
    m0_rdata   = m0_ack ? resp_rdata : 32'd0;
    m1_rdata   = m1_ack ? resp_rdata : 32'd0;
    m0_err     = m0_ack & lat_err;
    m1_err     = m1_ack & lat_err;
  end

endmodule
